network_interface: RTL and testbench
====================================

// Module: network_interface
// PURPOSE
//  Endpoint between a processing core and its local mesh router: packetises core
//  TX requests into NoC packets and injects them into the router's NI input port.
//  Receives packets the router delivers on its NI output, checks the destination,
//  buffers them and presents payload plus source coordinates to the core.
//  One instance per router tile; uses the same PACKET_WIDTH/XY coordinate format.
// PARAMETERS
//  GRID_WIDTH             4   mesh is GRID_WIDTH x GRID_WIDTH; COORD_WIDTH=$clog2(GRID_WIDTH)
//  NI_ROW                 0   row of this tile (COORD_WIDTH bits)
//  NI_COL                 0   column of this tile (COORD_WIDTH bits)
//  RX_FIFO_ADDRESS_WIDTH  2   RX buffer depth = 2**RX_FIFO_ADDRESS_WIDTH
//  DROP_COUNT_WIDTH       8   width of misrouted-packet counter
//  (localparam) PACKET_WIDTH = pa_noc::PACKET_WIDTH; PAYLOAD_WIDTH = PACKET_WIDTH-4*COORD_WIDTH
// PORTS
//  i_clk            in   1              clock
//  i_arst           in   1              async reset, active-high
//  i_txPayload      in   PAYLOAD_WIDTH  core payload to send
//  i_txDestRow      in   COORD_WIDTH    destination row
//  i_txDestCol      in   COORD_WIDTH    destination column
//  i_txValid        in   1              core TX request
//  o_txReady        out  1              NI accepts TX request this cycle
//  o_router         out  PACKET_WIDTH   packet to router NI input
//  o_routerValid    out  1              packet written into router this cycle
//  i_routerReady    in   1              router NI FIFO not full
//  i_router         in   PACKET_WIDTH   packet from router NI output
//  i_routerValid    in   1              router delivering packet
//  o_routerReady    out  1              RX buffer can accept
//  o_rxPayload      out  PAYLOAD_WIDTH  received payload (head of RX buffer)
//  o_rxSrcRow       out  COORD_WIDTH    sender row
//  o_rxSrcCol       out  COORD_WIDTH    sender column
//  o_rxValid        out  1              RX buffer non-empty
//  i_rxReady        in   1              core pops RX head
//  o_rxDropCount    out  DROP_COUNT_WIDTH  saturating count of misrouted packets
// BEHAVIOUR
//  Packet layout: [1:0]... generic: destCol @0, destRow @COORD_WIDTH, srcCol @2*CW,
//   srcRow @3*CW, payload @4*CW up to MSB. src fields always = NI_ROW/NI_COL.
//  TX FSM {TX_IDLE, TX_HOLD}; holding register txPacket.
//   - TX_IDLE: o_txReady=1; i_txValid -> capture packet, go TX_HOLD.
//   - TX_HOLD: o_routerValid = i_routerReady (combinational; router writes on valid
//     alone, so valid never asserts while ready low). o_txReady = i_routerReady.
//     If i_routerReady: packet transferred; if i_txValid also, capture new packet,
//     stay TX_HOLD, else go TX_IDLE. If !i_routerReady: hold packet unchanged.
//   - o_router = txPacket in TX_HOLD, '0 otherwise. Latency core->router >= 1 cycle;
//     sustained throughput 1 packet/cycle while router ready.
//   - Self-addressed packets (dest == own) sent normally.
//  RX path: o_routerReady = !rxFull. Transfer when i_routerValid && o_routerReady.
//   - dest fields == NI_ROW/NI_COL: written into RX FIFO.
//   - mismatch: discarded, o_rxDropCount += 1, saturates at all-ones.
//   - i_routerValid while full: packet is lost; not counted (router must not do this).
//   - o_rxValid = !rxEmpty; pop when o_rxValid && i_rxReady; i_rxReady with empty
//     buffer ignored. Simultaneous push+pop when full: push refused (ready low).
//   - o_rx* fields decode FIFO head; '0 when empty. Latency router->core 1 cycle.
//  Reset (any time, incl. mid-transfer): TX_IDLE, txPacket='0, RX FIFO emptied,
//   drop counter=0. Outputs during/after reset: o_txReady=1, o_routerValid=0,
//   o_router='0, o_routerReady=1, o_rxValid=0, o_rx*='0, o_rxDropCount=0.
// STRUCTURE
//  pa_noc: PACKET_WIDTH, field LSB constants, packed struct packet_t
//   {payload, srcRow, srcCol, destRow, destCol}, enum ni_tx_state_t.
//  Sub-module: synchronousFifo (DATA_W=PACKET_WIDTH, ADDR_W=RX_FIFO_ADDRESS_WIDTH)
//   as RX buffer, i_arst_n driven by !i_arst, writeEn gated by !full.
//  TX FSM, packetiser, drop filter and counter inline.
// TESTING (NI_ROW=1, NI_COL=2, GRID_WIDTH=4, PACKET_WIDTH=32, RX depth 4)
//  1 TX idle, router ready: payload 0xABCDEF, dest (3,0) -> next cycle o_routerValid=1,
//    o_router=0xABCDEF_6_C (src 1,2 / dest 3,0), FSM back to TX_IDLE.
//  2 TX backpressure: i_routerReady=0 for 5 cycles with packet held -> o_routerValid=0,
//    o_txReady=0, o_router stable; ready=1 -> exactly one transfer.
//  3 TX streaming: 8 back-to-back requests, router ready -> 8 packets in order, no gap.
//  4 RX fill: push 4 packets dest (1,2), i_rxReady=0 -> o_routerReady=0 after 4th;
//    pop all -> payload/src in order, o_rxValid drops after 4th pop.
//  5 RX misroute: 300 packets dest (0,0) -> none buffered, o_rxDropCount=255 (saturated).
//  6 Reset asserted while TX_HOLD and RX 2 entries -> all outputs at reset values,
//    no packet emitted after deassert.

Source files
------------

// File: rtl/network_interface_pkg.sv
// NoC packet format shared by routers and network interfaces.
package pa_noc;

  localparam int GRID_WIDTH    = 4;
  localparam int COORD_WIDTH   = $clog2(GRID_WIDTH);
  localparam int PACKET_WIDTH  = 32;
  localparam int PAYLOAD_WIDTH = PACKET_WIDTH - 4 * COORD_WIDTH;

  // Field LSB positions inside a packet, destination column at bit 0.
  localparam int DEST_COL_LSB = 0;
  localparam int DEST_ROW_LSB = COORD_WIDTH;
  localparam int SRC_COL_LSB  = 2 * COORD_WIDTH;
  localparam int SRC_ROW_LSB  = 3 * COORD_WIDTH;
  localparam int PAYLOAD_LSB  = 4 * COORD_WIDTH;

  typedef struct packed {
    logic [PAYLOAD_WIDTH-1:0] payload;
    logic [COORD_WIDTH-1:0]   srcRow;
    logic [COORD_WIDTH-1:0]   srcCol;
    logic [COORD_WIDTH-1:0]   destRow;
    logic [COORD_WIDTH-1:0]   destCol;
  } packet_t;

  typedef enum logic {
    TX_IDLE = 1'b0,
    TX_HOLD = 1'b1
  } ni_tx_state_t;

endpackage

// File: rtl/network_interface_fifo.sv
// Small synchronous FIFO with first-word fall-through head, used as RX buffer.
module synchronousFifo #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 2
) (
  input  logic              i_clk,
  input  logic              i_arst_n,
  input  logic              i_writeEn,
  input  logic [DATA_W-1:0] i_writeData,
  input  logic              i_readEn,
  output logic [DATA_W-1:0] o_readData,
  output logic              o_full,
  output logic              o_empty
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];
  // Pointers carry one extra wrap bit to tell full from empty.
  logic [ADDR_W:0]   wrPtr;
  logic [ADDR_W:0]   rdPtr;
  logic              doWrite;
  logic              doRead;

  assign doWrite    = i_writeEn && !o_full;
  assign doRead     = i_readEn && !o_empty;
  assign o_empty    = (wrPtr == rdPtr);
  assign o_full     = (wrPtr[ADDR_W] != rdPtr[ADDR_W]) &&
                      (wrPtr[ADDR_W-1:0] == rdPtr[ADDR_W-1:0]);
  assign o_readData = mem[rdPtr[ADDR_W-1:0]];

  // Pointer update; reset empties the buffer.
  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      wrPtr <= '0;
      rdPtr <= '0;
    end else begin
      if (doWrite) begin
        wrPtr <= wrPtr + (ADDR_W + 1)'(1);
      end
      if (doRead) begin
        rdPtr <= rdPtr + (ADDR_W + 1)'(1);
      end
    end
  end

  // Storage array; contents are don't-care while empty so no reset is needed.
  always_ff @(posedge i_clk) begin
    if (doWrite) begin
      mem[wrPtr[ADDR_W-1:0]] <= i_writeData;
    end
  end

endmodule

// File: rtl/network_interface.sv
// Network interface: packetises core TX requests for the local router and
// filters/buffers packets delivered by the router for the core.
module network_interface
  import pa_noc::*;
#(
  parameter int          GRID_WIDTH            = 4,
  parameter int unsigned NI_ROW                = 0,
  parameter int unsigned NI_COL                = 0,
  parameter int          RX_FIFO_ADDRESS_WIDTH = 2,
  parameter int          DROP_COUNT_WIDTH      = 8,
  localparam int         CW                    = $clog2(GRID_WIDTH),
  localparam int         PW                    = pa_noc::PACKET_WIDTH,
  localparam int         PLW                   = PW - 4 * CW
) (
  input  logic                        i_clk,
  input  logic                        i_arst,
  input  logic [PLW-1:0]              i_txPayload,
  input  logic [CW-1:0]               i_txDestRow,
  input  logic [CW-1:0]               i_txDestCol,
  input  logic                        i_txValid,
  output logic                        o_txReady,
  output logic [PW-1:0]               o_router,
  output logic                        o_routerValid,
  input  logic                        i_routerReady,
  input  logic [PW-1:0]               i_router,
  input  logic                        i_routerValid,
  output logic                        o_routerReady,
  output logic [PLW-1:0]              o_rxPayload,
  output logic [CW-1:0]               o_rxSrcRow,
  output logic [CW-1:0]               o_rxSrcCol,
  output logic                        o_rxValid,
  input  logic                        i_rxReady,
  output logic [DROP_COUNT_WIDTH-1:0] o_rxDropCount
);

  localparam logic [CW-1:0] OWN_ROW = CW'(NI_ROW);
  localparam logic [CW-1:0] OWN_COL = CW'(NI_COL);
  localparam logic [DROP_COUNT_WIDTH-1:0] DROP_MAX = {DROP_COUNT_WIDTH{1'b1}};

  ni_tx_state_t    txState;
  logic [PW-1:0]   txPacket;
  logic [PW-1:0]   newPacket;

  logic            rxFull;
  logic            rxEmpty;
  logic            rxTransfer;
  logic            destMatch;
  logic [PW-1:0]   rxHead;

  // Source fields are always this tile's own coordinates.
  assign newPacket = {i_txPayload, OWN_ROW, OWN_COL, i_txDestRow, i_txDestCol};

  // TX FSM and holding register: capture on accept, release when router ready.
  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) begin
      txState  <= TX_IDLE;
      txPacket <= '0;
    end else begin
      case (txState)
        TX_IDLE: begin
          if (i_txValid) begin
            txPacket <= newPacket;
            txState  <= TX_HOLD;
          end
        end
        TX_HOLD: begin
          if (i_routerReady) begin
            if (i_txValid) begin
              txPacket <= newPacket;
            end else begin
              txState <= TX_IDLE;
            end
          end
        end
        default: begin
          txState  <= TX_IDLE;
          txPacket <= '0;
        end
      endcase
    end
  end

  // Router writes on valid alone, so valid follows ready while holding a packet.
  always_comb begin
    o_txReady     = 1'b1;
    o_routerValid = 1'b0;
    o_router      = '0;
    case (txState)
      TX_IDLE: begin
        o_txReady = 1'b1;
      end
      TX_HOLD: begin
        o_txReady     = i_routerReady;
        o_routerValid = i_routerReady;
        o_router      = txPacket;
      end
      default: begin
        o_txReady = 1'b1;
      end
    endcase
  end

  assign o_routerReady = !rxFull;
  assign rxTransfer    = i_routerValid && !rxFull;
  assign destMatch     = (i_router[DEST_ROW_LSB +: CW] == OWN_ROW) &&
                         (i_router[DEST_COL_LSB +: CW] == OWN_COL);

  synchronousFifo #(
    .DATA_W (PW),
    .ADDR_W (RX_FIFO_ADDRESS_WIDTH)
  ) u_rxFifo (
    .i_clk       (i_clk),
    .i_arst_n    (!i_arst),
    .i_writeEn   (i_routerValid && !rxFull && destMatch),
    .i_writeData (i_router),
    .i_readEn    (i_rxReady && !rxEmpty),
    .o_readData  (rxHead),
    .o_full      (rxFull),
    .o_empty     (rxEmpty)
  );

  // Saturating count of accepted packets whose destination is another tile.
  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) begin
      o_rxDropCount <= '0;
    end else if (rxTransfer && !destMatch && (o_rxDropCount != DROP_MAX)) begin
      o_rxDropCount <= o_rxDropCount + DROP_COUNT_WIDTH'(1);
    end
  end

  // Decode the RX head for the core; all fields read zero while empty.
  always_comb begin
    o_rxValid   = 1'b0;
    o_rxPayload = '0;
    o_rxSrcRow  = '0;
    o_rxSrcCol  = '0;
    if (!rxEmpty) begin
      o_rxValid   = 1'b1;
      o_rxPayload = rxHead[PW-1:4*CW];
      o_rxSrcRow  = rxHead[3*CW +: CW];
      o_rxSrcCol  = rxHead[2*CW +: CW];
    end else begin
      o_rxValid = 1'b0;
    end
  end

endmodule

// File: tb/tb_network_interface.sv
// Directed testbench for network_interface at tile (1,2) of a 4x4 mesh.
module tb_network_interface;

  logic        i_clk;
  logic        i_arst;
  logic [23:0] i_txPayload;
  logic [1:0]  i_txDestRow;
  logic [1:0]  i_txDestCol;
  logic        i_txValid;
  logic        o_txReady;
  logic [31:0] o_router;
  logic        o_routerValid;
  logic        i_routerReady;
  logic [31:0] i_router;
  logic        i_routerValid;
  logic        o_routerReady;
  logic [23:0] o_rxPayload;
  logic [1:0]  o_rxSrcRow;
  logic [1:0]  o_rxSrcCol;
  logic        o_rxValid;
  logic        i_rxReady;
  logic [7:0]  o_rxDropCount;

  int vectors = 0;
  int fails   = 0;

  network_interface #(
    .GRID_WIDTH            (4),
    .NI_ROW                (1),
    .NI_COL                (2),
    .RX_FIFO_ADDRESS_WIDTH (2),
    .DROP_COUNT_WIDTH      (8)
  ) dut (
    .i_clk         (i_clk),
    .i_arst        (i_arst),
    .i_txPayload   (i_txPayload),
    .i_txDestRow   (i_txDestRow),
    .i_txDestCol   (i_txDestCol),
    .i_txValid     (i_txValid),
    .o_txReady     (o_txReady),
    .o_router      (o_router),
    .o_routerValid (o_routerValid),
    .i_routerReady (i_routerReady),
    .i_router      (i_router),
    .i_routerValid (i_routerValid),
    .o_routerReady (o_routerReady),
    .o_rxPayload   (o_rxPayload),
    .o_rxSrcRow    (o_rxSrcRow),
    .o_rxSrcCol    (o_rxSrcCol),
    .o_rxValid     (o_rxValid),
    .i_rxReady     (i_rxReady),
    .o_rxDropCount (o_rxDropCount)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Advance to just after the next rising edge; inputs are driven and outputs sampled here.
  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic test_reset();
    i_arst = 1'b1;
    i_txPayload = 24'h0; i_txDestRow = 2'd0; i_txDestCol = 2'd0; i_txValid = 1'b0;
    i_routerReady = 1'b1; i_router = 32'h0; i_routerValid = 1'b0; i_rxReady = 1'b0;
    tick();
    tick();
    vectors++; if (o_txReady !== 1'b1) begin fails++; $display("FAIL reset_txReady got %b want 1", o_txReady); end
    vectors++; if (o_routerValid !== 1'b0) begin fails++; $display("FAIL reset_routerValid got %b want 0", o_routerValid); end
    vectors++; if (o_router !== 32'h0) begin fails++; $display("FAIL reset_router got %h want 0", o_router); end
    vectors++; if (o_routerReady !== 1'b1) begin fails++; $display("FAIL reset_routerReady got %b want 1", o_routerReady); end
    vectors++; if (o_rxValid !== 1'b0) begin fails++; $display("FAIL reset_rxValid got %b want 0", o_rxValid); end
    vectors++; if (o_rxDropCount !== 8'd0) begin fails++; $display("FAIL reset_dropCount got %0d want 0", o_rxDropCount); end
    i_arst = 1'b0;
    tick();
  endtask

  task automatic test_tx_single();
    i_txPayload = 24'hABCDEF; i_txDestRow = 2'd3; i_txDestCol = 2'd0; i_txValid = 1'b1;
    i_routerReady = 1'b1;
    vectors++; if (o_txReady !== 1'b1) begin fails++; $display("FAIL tx1_idleReady got %b want 1", o_txReady); end
    vectors++; if (o_routerValid !== 1'b0) begin fails++; $display("FAIL tx1_noEarlyValid got %b want 0", o_routerValid); end
    tick();
    i_txValid = 1'b0;
    vectors++; if (o_routerValid !== 1'b1) begin fails++; $display("FAIL tx1_valid got %b want 1", o_routerValid); end
    vectors++; if (o_router !== 32'hABCDEF6C) begin fails++; $display("FAIL tx1_packet got %h want abcdef6c", o_router); end
    tick();
    vectors++; if (o_routerValid !== 1'b0) begin fails++; $display("FAIL tx1_backIdle got %b want 0", o_routerValid); end
    vectors++; if (o_router !== 32'h0) begin fails++; $display("FAIL tx1_idleRouter got %h want 0", o_router); end
  endtask

  task automatic test_tx_backpressure();
    int transfers;
    transfers = 0;
    i_routerReady = 1'b0;
    i_txPayload = 24'h123456; i_txDestRow = 2'd0; i_txDestCol = 2'd1; i_txValid = 1'b1;
    tick();
    i_txValid = 1'b0;
    i_txPayload = 24'h999999;
    for (int c = 0; c < 5; c++) begin
      vectors++; if (o_routerValid !== 1'b0) begin fails++; $display("FAIL bp_valid[%0d] got %b want 0", c, o_routerValid); end
      vectors++; if (o_txReady !== 1'b0) begin fails++; $display("FAIL bp_txReady[%0d] got %b want 0", c, o_txReady); end
      vectors++; if (o_router !== 32'h12345661) begin fails++; $display("FAIL bp_hold[%0d] got %h want 12345661", c, o_router); end
      tick();
    end
    i_routerReady = 1'b1;
    #1;
    vectors++; if (o_routerValid !== 1'b1) begin fails++; $display("FAIL bp_release got %b want 1", o_routerValid); end
    vectors++; if (o_router !== 32'h12345661) begin fails++; $display("FAIL bp_releasePkt got %h want 12345661", o_router); end
    for (int c = 0; c < 4; c++) begin
      @(negedge i_clk);
      if (o_routerValid === 1'b1) transfers++;
    end
    tick();
    vectors++; if (transfers !== 1) begin fails++; $display("FAIL bp_transferCount got %0d want 1", transfers); end
  endtask

  task automatic test_tx_stream();
    logic [31:0] exp;
    i_routerReady = 1'b1;
    i_txDestRow = 2'd2; i_txDestCol = 2'd3;
    i_txPayload = 24'h000100; i_txValid = 1'b1;
    tick();
    for (int k = 1; k < 8; k++) begin
      i_txPayload = 24'h000100 + 24'(k);
      exp = {24'h000100 + 24'(k - 1), 8'h6B};
      #1;
      vectors++; if (o_routerValid !== 1'b1) begin fails++; $display("FAIL stream_valid[%0d] got %b want 1", k - 1, o_routerValid); end
      vectors++; if (o_router !== exp) begin fails++; $display("FAIL stream_pkt[%0d] got %h want %h", k - 1, o_router, exp); end
      vectors++; if (o_txReady !== 1'b1) begin fails++; $display("FAIL stream_ready[%0d] got %b want 1", k, o_txReady); end
      tick();
    end
    i_txValid = 1'b0;
    #1;
    vectors++; if (o_router !== 32'h0001076B || o_routerValid !== 1'b1) begin fails++; $display("FAIL stream_last got %h/%b want 0001076b/1", o_router, o_routerValid); end
    tick();
    vectors++; if (o_routerValid !== 1'b0) begin fails++; $display("FAIL stream_end got %b want 0", o_routerValid); end
  endtask

  task automatic test_rx_fill();
    logic [1:0] r;
    logic [1:0] c;
    i_rxReady = 1'b0;
    i_routerValid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      r = 2'(k);
      c = 2'(3 - k);
      i_router = {24'hA00000 + 24'(k), r, c, 4'h6};
      #1;
      vectors++; if (o_routerReady !== 1'b1) begin fails++; $display("FAIL fill_ready[%0d] got %b want 1", k, o_routerReady); end
      tick();
    end
    i_routerValid = 1'b0;
    vectors++; if (o_routerReady !== 1'b0) begin fails++; $display("FAIL fill_full got %b want 0", o_routerReady); end
    vectors++; if (o_rxDropCount !== 8'd0) begin fails++; $display("FAIL fill_noDrop got %0d want 0", o_rxDropCount); end
    i_rxReady = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      vectors++; if (o_rxValid !== 1'b1) begin fails++; $display("FAIL pop_valid[%0d] got %b want 1", k, o_rxValid); end
      vectors++; if (o_rxPayload !== 24'hA00000 + 24'(k)) begin fails++; $display("FAIL pop_payload[%0d] got %h want %h", k, o_rxPayload, 24'hA00000 + 24'(k)); end
      vectors++; if (o_rxSrcRow !== 2'(k) || o_rxSrcCol !== 2'(3 - k)) begin fails++; $display("FAIL pop_src[%0d] got %0d,%0d want %0d,%0d", k, o_rxSrcRow, o_rxSrcCol, k, 3 - k); end
      tick();
    end
    vectors++; if (o_rxValid !== 1'b0) begin fails++; $display("FAIL pop_empty got %b want 0", o_rxValid); end
    vectors++; if (o_rxPayload !== 24'h0) begin fails++; $display("FAIL pop_emptyPayload got %h want 0", o_rxPayload); end
    tick();
    vectors++; if (o_rxValid !== 1'b0 || o_routerReady !== 1'b1) begin fails++; $display("FAIL pop_extraIgnored got %b/%b want 0/1", o_rxValid, o_routerReady); end
    i_rxReady = 1'b0;
  endtask

  task automatic test_rx_misroute();
    i_router = {24'h000055, 2'd1, 2'd2, 2'd0, 2'd0};
    i_routerValid = 1'b1;
    for (int i = 1; i <= 300; i++) begin
      tick();
      if (i == 10) begin
        vectors++; if (o_rxDropCount !== 8'd10) begin fails++; $display("FAIL drop_count10 got %0d want 10", o_rxDropCount); end
      end
    end
    i_routerValid = 1'b0;
    vectors++; if (o_rxDropCount !== 8'd255) begin fails++; $display("FAIL drop_saturate got %0d want 255", o_rxDropCount); end
    vectors++; if (o_rxValid !== 1'b0) begin fails++; $display("FAIL drop_noneBuffered got %b want 0", o_rxValid); end
  endtask

  task automatic test_reset_midflight();
    i_routerReady = 1'b0;
    i_txPayload = 24'h777777; i_txDestRow = 2'd0; i_txDestCol = 2'd0; i_txValid = 1'b1;
    tick();
    i_txValid = 1'b0;
    i_router = {24'hBEEF00, 2'd0, 2'd0, 2'd1, 2'd2};
    i_routerValid = 1'b1;
    tick();
    tick();
    i_routerValid = 1'b0;
    vectors++; if (o_rxValid !== 1'b1 || o_txReady !== 1'b0) begin fails++; $display("FAIL rst_setup got rxValid %b txReady %b want 1/0", o_rxValid, o_txReady); end
    i_arst = 1'b1;
    #1;
    vectors++; if (o_txReady !== 1'b1) begin fails++; $display("FAIL rst_txReady got %b want 1", o_txReady); end
    vectors++; if (o_routerValid !== 1'b0 || o_router !== 32'h0) begin fails++; $display("FAIL rst_router got %b/%h want 0/0", o_routerValid, o_router); end
    vectors++; if (o_routerReady !== 1'b1) begin fails++; $display("FAIL rst_routerReady got %b want 1", o_routerReady); end
    vectors++; if (o_rxValid !== 1'b0 || o_rxPayload !== 24'h0 || o_rxSrcRow !== 2'd0 || o_rxSrcCol !== 2'd0) begin fails++; $display("FAIL rst_rx got %b/%h/%0d/%0d want 0/0/0/0", o_rxValid, o_rxPayload, o_rxSrcRow, o_rxSrcCol); end
    vectors++; if (o_rxDropCount !== 8'd0) begin fails++; $display("FAIL rst_dropCount got %0d want 0", o_rxDropCount); end
    tick();
    i_arst = 1'b0;
    i_routerReady = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      vectors++; if (o_routerValid !== 1'b0 || o_rxValid !== 1'b0) begin fails++; $display("FAIL rst_after[%0d] got %b/%b want 0/0", c, o_routerValid, o_rxValid); end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_tx_single();
    test_tx_backpressure();
    test_tx_stream();
    test_rx_fill();
    test_rx_misroute();
    test_reset_midflight();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
